// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot count stream consumer.
// The rotate helper is written for any width up to MaxWidth bits.
package onehot_pkg;

    localparam int MaxWidth = 64;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_SEQ     = 2'd2
    } err_e;

    typedef enum logic {
        TRACK  = 1'b0,
        RESYNC = 1'b1
    } track_state_e;

    // Rotate the low w bits of v left by one; bits at or above w must be 0.
    function automatic logic [MaxWidth-1:0] rotl1(
        input logic [MaxWidth-1:0] v,
        input int                  w
    );
        logic [MaxWidth-1:0] mask;
        mask = '1 >> (MaxWidth - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary converter with legality flag (exactly one bit hot).
// Purely combinational; the index is 0 whenever the input is illegal.
module onehot_to_bin #(
    parameter int width_p = 8
) (
    input  logic [width_p-1:0]         onehot_i,
    output logic [$clog2(width_p)-1:0] index_o,
    output logic                       legal_o
);

    localparam int IdxW = $clog2(width_p);

    logic [IdxW-1:0] idx_or;

    // OR together the positions of all set bits; exact for a legal input.
    always_comb begin
        idx_or = '0;
        for (int i = 0; i < width_p; i++) begin
            if (onehot_i[i]) idx_or = idx_or | IdxW'(i);
        end
    end

    assign legal_o = (onehot_i != '0) &&
                     ((onehot_i & (onehot_i - 1'b1)) == '0);
    assign index_o = legal_o ? idx_or : '0;

endmodule

// File: rtl/onehot_tracker.sv
// Consumer of the one-hot count stream: legality, progression, wrap count.
// Define ONEHOT_TRACKER_SEQ_CHECK_EN to enable the progression (SEQ) check.
module onehot_tracker
    import onehot_pkg::*;
#(
    parameter int width_p      = 8,
    parameter int wrap_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         onehot_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(width_p)-1:0] index_o,
    output logic                       wrap_o,
    output logic [wrap_width_p-1:0]    wrap_count_o,
    output logic [1:0]                 err_o,
    output logic                       err_sticky_o
);

    localparam int IdxW = $clog2(width_p);

    logic                    valid_q, valid_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    err_e                    err_q, err_d;
    logic [wrap_width_p-1:0] cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;

    logic            accept;
    logic            legal;
    logic            msb_hit;
    logic [IdxW-1:0] idx_c;
    err_e            code;

    onehot_to_bin #(.width_p(width_p)) u_conv (
        .onehot_i (onehot_i),
        .index_o  (idx_c),
        .legal_o  (legal)
    );

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;
    assign msb_hit = legal & onehot_i[width_p-1];

`ifdef ONEHOT_TRACKER_SEQ_CHECK_EN
    track_state_e         state_q, state_d;
    logic [width_p-1:0]   exp_q, exp_d;
    logic [MaxWidth-1:0]  rot_w;
    logic                 unused_rot;

    assign rot_w      = rotl1(MaxWidth'(onehot_i), width_p);
    assign unused_rot = ^rot_w;

    // Progression tracker: state register and expected next vector.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= TRACK;
            exp_q   <= width_p'(1);
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    // Classify the sample and advance the tracker on accept.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        code    = ERR_OK;
        if (!legal) begin
            code = ERR_ILLEGAL;
        end else if (state_q == TRACK && onehot_i != exp_q) begin
            code = ERR_SEQ;
        end
        if (accept) begin
            if (!legal) begin
                state_d = RESYNC;
            end else begin
                state_d = TRACK;
                exp_d   = rot_w[width_p-1:0];
            end
        end
    end
`else
    // Without progression tracking only legality is reported.
    always_comb begin
        code = legal ? ERR_OK : ERR_ILLEGAL;
    end
`endif

    // Output stage next state: load on accept, drop valid on drain.
    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        wrap_d   = wrap_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (accept) begin
            valid_d  = 1'b1;
            idx_d    = idx_c;
            wrap_d   = msb_hit;
            err_d    = code;
            cnt_d    = cnt_q + wrap_width_p'(msb_hit);
            sticky_d = sticky_q | (code != ERR_OK);
        end else if (ready_i) begin
            valid_d  = 1'b0;
        end
    end

    // Output stage and running counters.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign valid_o      = valid_q;
    assign index_o      = idx_q;
    assign wrap_o       = wrap_q;
    assign err_o        = err_q;
    assign wrap_count_o = cnt_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_onehot_tracker.sv
// Directed bench for onehot_tracker (width 8, 16-bit wrap counter).
// Expected error codes follow ONEHOT_TRACKER_SEQ_CHECK_EN when defined.
module tb_onehot_tracker;

`ifdef ONEHOT_TRACKER_SEQ_CHECK_EN
    localparam bit Seq = 1'b1;
`else
    localparam bit Seq = 1'b0;
`endif
    localparam logic [1:0] ESeq = Seq ? 2'd2 : 2'd0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  onehot_i;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  index_o;
    logic        wrap_o;
    logic [15:0] wrap_count_o;
    logic [1:0]  err_o;
    logic        err_sticky_o;

    int errors = 0;
    int checks = 0;

    onehot_tracker #(.width_p(8), .wrap_width_p(16)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .onehot_i     (onehot_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .index_o      (index_o),
        .wrap_o       (wrap_o),
        .wrap_count_o (wrap_count_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic r);
        valid_i  = v;
        onehot_i = d;
        ready_i  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic [2:0] idx,
                       input logic wr, input logic [1:0] er,
                       input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(valid_o), 32'd1);
        chk({tag, ".index"}, 32'(index_o), 32'(idx));
        chk({tag, ".wrap"},  32'(wrap_o),  32'(wr));
        chk({tag, ".err"},   32'(err_o),   32'(er));
        chk({tag, ".cnt"},   32'(wrap_count_o), 32'(cnt));
    endtask

    initial begin
        reset_n  = 1'b0;
        valid_i  = 1'b0;
        onehot_i = 8'h00;
        ready_i  = 1'b1;
        send(1'b0, 8'h00, 1'b1);
        send(1'b1, 8'h01, 1'b1);
        chk("rst.valid",  32'(valid_o), 32'd0);
        chk("rst.index",  32'(index_o), 32'd0);
        chk("rst.cnt",    32'(wrap_count_o), 32'd0);
        chk("rst.sticky", 32'(err_sticky_o), 32'd0);
        chk("rst.ready",  32'(ready_o), 32'd1);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            send(1'b1, 8'h01 << (i % 8), 1'b1);
            res("walk", 3'(i % 8), i == 7, 2'd0, (i >= 7) ? 16'd1 : 16'd0);
        end
        chk("walk.sticky", 32'(err_sticky_o), 32'd0);

        send(1'b1, 8'h01, 1'b1);
        res("seq01", 3'd0, 1'b0, ESeq, 16'd1);
        send(1'b1, 8'h04, 1'b1);
        res("seq04", 3'd2, 1'b0, ESeq, 16'd1);
        chk("seq.sticky", 32'(err_sticky_o), 32'(Seq));
        send(1'b1, 8'h08, 1'b1);
        res("seq08", 3'd3, 1'b0, 2'd0, 16'd1);

        send(1'b1, 8'h00, 1'b1);
        res("ill00", 3'd0, 1'b0, 2'd1, 16'd1);
        chk("ill.sticky", 32'(err_sticky_o), 32'd1);
        send(1'b1, 8'h03, 1'b1);
        res("ill03", 3'd0, 1'b0, 2'd1, 16'd1);
        send(1'b1, 8'h20, 1'b1);
        res("resync20", 3'd5, 1'b0, 2'd0, 16'd1);
        send(1'b1, 8'h40, 1'b1);
        res("trk40", 3'd6, 1'b0, 2'd0, 16'd1);
        send(1'b1, 8'h81, 1'b1);
        res("ill81", 3'd0, 1'b0, 2'd1, 16'd1);
        send(1'b1, 8'h80, 1'b1);
        res("resync80", 3'd7, 1'b1, 2'd0, 16'd2);
        send(1'b1, 8'h01, 1'b1);
        res("trk01", 3'd0, 1'b0, 2'd0, 16'd2);

        for (int i = 0; i < 3; i++) begin
            send(1'b1, 8'h02, 1'b0);
            chk("stall.ready", 32'(ready_o), 32'd0);
            res("stall", 3'd0, 1'b0, 2'd0, 16'd2);
        end
        send(1'b1, 8'h02, 1'b1);
        res("unstall", 3'd1, 1'b0, 2'd0, 16'd2);
        send(1'b0, 8'hff, 1'b1);
        chk("drain.valid", 32'(valid_o), 32'd0);
        send(1'b1, 8'h04, 1'b1);
        res("idle04", 3'd2, 1'b0, 2'd0, 16'd2);

        for (int i = 3; i < 8; i++) begin
            send(1'b1, 8'h01 << i, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                send(1'b1, 8'h01 << i, 1'b1);
            end
        end
        res("pre_rst", 3'd7, 1'b1, 2'd0, 16'd5);

        reset_n = 1'b0;
        send(1'b1, 8'h04, 1'b0);
        chk("mrst.valid",  32'(valid_o), 32'd0);
        chk("mrst.index",  32'(index_o), 32'd0);
        chk("mrst.wrap",   32'(wrap_o), 32'd0);
        chk("mrst.err",    32'(err_o), 32'd0);
        chk("mrst.cnt",    32'(wrap_count_o), 32'd0);
        chk("mrst.sticky", 32'(err_sticky_o), 32'd0);
        reset_n = 1'b1;
        send(1'b1, 8'h02, 1'b1);
        res("post02", 3'd1, 1'b0, ESeq, 16'd0);
        chk("post.sticky", 32'(err_sticky_o), 32'(Seq));

        send(1'b1, 8'h01, 1'b1);
        res("cfg01", 3'd0, 1'b0, ESeq, 16'd0);
        send(1'b1, 8'h08, 1'b1);
        res("cfg08", 3'd3, 1'b0, ESeq, 16'd0);
        send(1'b1, 8'h00, 1'b1);
        res("cfg00", 3'd0, 1'b0, 2'd1, 16'd0);
        chk("cfg.sticky", 32'(err_sticky_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
